// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory fetch bus: level request held until a one-cycle ack,
// with read data valid in the ack cycle.
interface if_fetch_ctrl_if #(
    parameter int W = 32
);
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_ack;
    logic [W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one memory request
// per instruction, and feeds decode through a registered stage plus a one-entry skid.
module if_fetch_ctrl #(
    parameter int           W        = 32,
    parameter logic [W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [W-1:0]          redirect_pc,
    if_fetch_ctrl_if.master       imem,
    output logic                  inst_valid,
    output logic [W-1:0]          inst,
    output logic [W-1:0]          inst_pc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FULL,
        S_DROP
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] fetch_pc_q, fetch_pc_d;
    logic [W-1:0] drop_pc_q, drop_pc_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic [W-1:0] skid_pc_q, skid_pc_d;
    logic         inst_valid_q, inst_valid_d;
    logic [W-1:0] inst_q, inst_d;
    logic [W-1:0] inst_pc_q, inst_pc_d;

    logic         out_free;
    logic         consumed;
    logic [W-1:0] pc_plus4;

    assign out_free = !inst_valid_q || !stall;
    assign consumed = inst_valid_q && !stall;
    assign pc_plus4 = fetch_pc_q + W'(4);

    // In DROP the PC still holds the stale address, so it is always the bus address.
    assign imem.imem_req  = (state_q == S_WAIT) || (state_q == S_DROP);
    assign imem.imem_addr = fetch_pc_q;

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

    always_comb begin
        // NOTE: every *_d defaults to its *_q first, so no path leaves a variable unassigned and no latch is inferred.
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drop_pc_d    = drop_pc_q;
        skid_data_d  = skid_data_q;
        skid_pc_d    = skid_pc_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_WAIT;
                if (redirect) begin
                    fetch_pc_d   = redirect_pc;
                    inst_valid_d = 1'b0;
                end
            end

            S_WAIT: begin
                if (redirect) begin
                    inst_valid_d = 1'b0;
                    if (imem.imem_ack) begin
                        fetch_pc_d = redirect_pc;
                    end else begin
                        drop_pc_d = redirect_pc;
                        state_d   = S_DROP;
                    end
                end else if (imem.imem_ack) begin
                    fetch_pc_d = pc_plus4;
                    if (out_free) begin
                        inst_d       = imem.imem_rdata;
                        inst_pc_d    = fetch_pc_q;
                        inst_valid_d = 1'b1;
                    end else begin
                        skid_data_d = imem.imem_rdata;
                        skid_pc_d   = fetch_pc_q;
                        state_d     = S_FULL;
                    end
                end else if (consumed) begin
                    inst_valid_d = 1'b0;
                end
            end

            // Skid occupancy is implied by this state; leaving it empties the skid.
            S_FULL: begin
                if (redirect) begin
                    inst_valid_d = 1'b0;
                    fetch_pc_d   = redirect_pc;
                    state_d      = S_WAIT;
                end else if (!stall) begin
                    inst_d       = skid_data_q;
                    inst_pc_d    = skid_pc_q;
                    inst_valid_d = 1'b1;
                    state_d      = S_WAIT;
                end
            end

            S_DROP: begin
                if (imem.imem_ack) begin
                    fetch_pc_d = redirect ? redirect_pc : drop_pc_q;
                    state_d    = S_WAIT;
                end else if (redirect) begin
                    drop_pc_d = redirect_pc;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= RESET_PC;
            drop_pc_q    <= RESET_PC;
            skid_data_q  <= '0;
            skid_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
        end else begin
            // NOTE: non-blocking updates make all flops sample the same pre-edge values, independent of statement order.
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            drop_pc_q    <= drop_pc_d;
            skid_data_q  <= skid_data_d;
            skid_pc_q    <= skid_pc_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed timing scenarios, then a randomized run
// checked against a program-order stream model (PC sequence plus redirects).
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ack_en = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int checks = 0;
    int errors = 0;

    if_fetch_ctrl_if #(.W(32)) bus ();

    if_fetch_ctrl #(.W(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    // Memory answers only while a request is outstanding.
    assign bus.imem_ack   = ack_en & bus.imem_req;
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle after reset release (IDLE).
    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        ack_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic        exp_pending;
    logic [31:0] prev_addr;
    logic [31:0] exp_pc;
    logic [31:0] rpc;
    int          idle_cnt;
    int          consumed_cnt;

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        rst = 1'b0;

        // Zero-wait streaming
        check("idle_req", 32'(bus.imem_req), 32'd0);
        ack_en = 1'b1;
        tick();
        check("c2_req", 32'(bus.imem_req), 32'd1);
        check("c2_addr", bus.imem_addr, 32'h0);
        check("c2_valid", 32'(inst_valid), 32'd0);
        tick();
        check("c3_addr", bus.imem_addr, 32'h4);
        check("c3_valid", 32'(inst_valid), 32'd1);
        check("c3_pc", inst_pc, 32'h0);
        check("c3_inst", inst, mem_word(32'h0));
        tick();
        check("c4_addr", bus.imem_addr, 32'h8);
        check("c4_pc", inst_pc, 32'h4);

        // Stall for three cycles with ack arriving: skid fills, requests pause
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_req_low", 32'(bus.imem_req), 32'd0);
            check("stall_hold_pc", inst_pc, 32'h4);
            check("stall_hold_valid", 32'(inst_valid), 32'd1);
        end
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("drain_valid", 32'(inst_valid), 32'd1);
            check("drain_pc", inst_pc, 32'h8 + 32'(4 * i));
            check("drain_inst", inst, mem_word(32'h8 + 32'(4 * i)));
        end

        // Redirect during a slow fetch: stale address held, data discarded
        do_reset();
        tick();
        check("slow_addr", bus.imem_addr, 32'h0);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("drop_req", 32'(bus.imem_req), 32'd1);
            check("drop_addr", bus.imem_addr, 32'h0);
            check("drop_valid", 32'(inst_valid), 32'd0);
            tick();
        end
        check("drop_addr_last", bus.imem_addr, 32'h0);
        ack_en = 1'b1;
        tick();
        check("post_drop_addr", bus.imem_addr, 32'h100);
        check("post_drop_valid", 32'(inst_valid), 32'd0);
        tick();
        check("first_redir_valid", 32'(inst_valid), 32'd1);
        check("first_redir_pc", inst_pc, 32'h100);
        check("first_redir_inst", inst, mem_word(32'h100));

        // Redirect coinciding with ack
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        check("redir_ack_addr", bus.imem_addr, 32'h200);
        check("redir_ack_valid", 32'(inst_valid), 32'd0);
        tick();
        check("redir_ack_pc", inst_pc, 32'h200);

        // Redirect while the skid is full
        stall = 1'b1;
        tick();
        check("full_req", 32'(bus.imem_req), 32'd0);
        redirect = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        check("full_redir_valid", 32'(inst_valid), 32'd0);
        check("full_redir_req", 32'(bus.imem_req), 32'd1);
        check("full_redir_addr", bus.imem_addr, 32'h300);
        tick();
        check("full_redir_pc", inst_pc, 32'h300);
        check("full_redir_inst", inst, mem_word(32'h300));

        // Address wrap at the top of the space
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check("wrap_top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr", bus.imem_addr, 32'h0);
        check("wrap_pc", inst_pc, 32'hFFFF_FFFC);

        // Asynchronous reset mid-transaction
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_req", 32'(bus.imem_req), 32'd0);
        check("async_rst_valid", 32'(inst_valid), 32'd0);
        check("async_rst_addr", bus.imem_addr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rerun_idle_req", 32'(bus.imem_req), 32'd0);
        tick();
        check("rerun_addr", bus.imem_addr, 32'h0);
        tick();
        check("rerun_pc", inst_pc, 32'h0);
        check("rerun_valid", 32'(inst_valid), 32'd1);

        // Randomized run against the program-order stream model
        do_reset();
        exp_pc = 32'h0;
        exp_pending = 1'b0;
        prev_addr = '0;
        idle_cnt = 0;
        consumed_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (exp_pending) begin
                check("rand_req_held", 32'(bus.imem_req), 32'd1);
                check("rand_addr_stable", bus.imem_addr, prev_addr);
            end
            stall    = ($urandom_range(0, 9) < 3);
            redirect = ($urandom_range(0, 19) == 0);
            ack_en   = ($urandom_range(0, 9) < 6);
            rpc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF4;
            redirect_pc = rpc;
            #1;
            if (inst_valid && !stall) begin
                check("rand_pc", inst_pc, exp_pc);
                check("rand_inst", inst, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                idle_cnt = 0;
                consumed_cnt++;
            end else begin
                idle_cnt++;
            end
            if (idle_cnt > 200) begin
                check("rand_liveness", 32'(idle_cnt), 32'd0);
                break;
            end
            if (redirect) exp_pc = rpc;
            exp_pending = bus.imem_req && !bus.imem_ack;
            prev_addr = bus.imem_addr;
            tick();
        end
        check("rand_progress", 32'(consumed_cnt > 300), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch sequencer between the PC/fetch stage and instruction memory. Holds the fetch PC, runs a level req/ack transaction per instruction, and presents fetched words to decode through a registered output stage with a one-entry skid buffer. Applies branch redirects from the branch unit and discards any in-flight stale fetch. Sustains one instruction per cycle with a zero-wait memory.

## Interface
- `W`, 32, word/address width
- `RESET_PC`, 0, first fetch address after reset
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `stall`  in  1  decode cannot accept the presented instruction this cycle
- `redirect`  in  1  taken branch/jump resolved; fetch restarts at `redirect_pc`
- `redirect_pc`  in  W  redirect target
- `imem_req`  out  1  fetch request, held high until `imem_ack`
- `imem_addr`  out  W  fetch address, stable while `imem_req` is high
- `imem_ack`  in  1  one-cycle completion; `imem_rdata` valid in the same cycle
- `imem_rdata`  in  W  fetched word
- `inst_valid`  out  1  `inst`/`inst_pc` hold a valid instruction for decode
- `inst`  out  W  instruction word (registered)
- `inst_pc`  out  W  address of `inst` (registered)

## Operation
- Reset: state IDLE; `fetch_pc`=RESET_PC; skid empty; `imem_req`=0; `imem_addr`=RESET_PC; `inst_valid`=0; `inst`=0; `inst_pc`=0.
- Handshake: decode consumes the output when `inst_valid && !stall`. `out_free` = `!inst_valid || !stall`.
- `imem_req` is 1 in WAIT and DROP, 0 in IDLE and FULL. `imem_addr` = `fetch_pc`, except in DROP where it is the stale address.
- IDLE: advance to WAIT the next cycle. A redirect in this cycle loads `fetch_pc`=`redirect_pc`.
- WAIT:
  - ack and redirect: discard `rdata`; `fetch_pc`=`redirect_pc`; `inst_valid`=0; stay in WAIT.
  - redirect without ack: latch `redirect_pc` into `drop_pc`; `inst_valid`=0; go to DROP. The address is not changed mid-transaction.
  - ack, no redirect, `out_free`: `inst`=`rdata`, `inst_pc`=`fetch_pc`, `inst_valid`=1; `fetch_pc`+=4; stay in WAIT.
  - ack, no redirect, not `out_free`: skid captures (`rdata`, `fetch_pc`); `fetch_pc`+=4; go to FULL.
  - no ack, no redirect: if the output is consumed, `inst_valid`=0.
- FULL:
  - redirect: clear the skid; `inst_valid`=0; `fetch_pc`=`redirect_pc`; go to WAIT.
  - else if `!stall`: the output loads from the skid; go to WAIT.
  - else: hold.
- DROP:
  - on ack: discard `rdata`; `fetch_pc`=`drop_pc`; go to WAIT.
  - a further redirect updates `drop_pc`, with the latest redirect winning; if it coincides with ack, that `redirect_pc` is used directly.
- Priority: `rst` > `redirect` > `imem_ack` > `stall`. A redirect always invalidates the output and the skid at the next edge.
- Arithmetic: `fetch_pc`+4 is modulo 2^W, so 0xFFFFFFFC wraps to 0x00000000. `redirect_pc` is used unmodified; alignment is the branch unit's responsibility.
- Mid-operation `rst` aborts any transaction immediately. The memory must tolerate `imem_req` dropping without ack.

## Timing
- First `imem_req` rises in the second cycle after `rst` deasserts (IDLE lasts one cycle).
- Ack latency to `inst_valid` is 1 cycle. With ack in every cycle and no stall, throughput is one instruction per cycle.
- Redirect in cycle t with ack: `imem_addr`=`redirect_pc` in cycle t+1. The first redirected instruction is valid at t+2 with zero-wait memory.
- Redirect without ack adds the remaining latency of the stale fetch before the new request.
- With the skid full, no request is issued until decode drains one entry. No instruction is ever lost or duplicated.

## Test plan
- Reset, zero-wait memory, no stall → `imem_addr` sequence 0,4,8,12; `inst_valid` continuously high from the 3rd cycle; each `inst_pc` matches its word.
- `stall` held for 3 cycles while ack keeps arriving → state goes to FULL and `imem_req` drops; after release `inst_pc` sequence 8,12,16 with no gap, loss or duplication.
- Ack delayed 4 cycles, redirect to 0x100 in cycle 2 → stale address held, its data is discarded, next request is at 0x100, and `inst_valid` stays 0 until the 0x100 instruction arrives.
- Redirect and ack in the same cycle, and redirect while in FULL → next `imem_addr`=`redirect_pc`; skid and output invalidated.
- `redirect_pc`=0xFFFFFFFC, then sequential fetch → next `imem_addr`=0x00000000.
- `rst` asserted mid-WAIT → `imem_req` and `inst_valid` go to 0 immediately (asynchronous); after release, fetch restarts at RESET_PC.
